// File: rtl/spike_decoder.sv
// spike_decoder
//   Output stage after the LIF network. It counts each class neuron's spikes
//   over a window of WINDOW clocks, scans the counts one class per cycle to
//   pick the winner, and holds the result on a valid/ready handshake. At the
//   start of each window it sends a one-cycle clear to the network.
//
// Optional feature: define SPIKE_DEC_FIRST_SPIKE_EN to add a first-spike
//   timestamp per class. Equal counts are then won by the earlier first spike.
//   Without the macro, equal counts are won by the lowest class index.
//
// Ports
//   clk        in   clock, rising edge
//   rstn       in   synchronous active-low reset
//   start_i    in   request one classification window
//   spikes_i   in   [N_CLASS]  network output spikes, bit k = class k
//   busy_o     out  high in RUN/DECIDE/HOLD
//   net_clr_o  out  one-cycle network clear, first RUN cycle
//   valid_o    out  result available (HOLD)
//   ready_i    in   consumer accepts result
//   class_o    out  [CLS_W]  winning class index
//   count_o    out  [CNT_W]  spike count of winning class
//   none_o     out  all class counts zero in this window
module spike_decoder #(
  parameter int N_CLASS = 2,
  parameter int WINDOW  = 64,
  parameter int CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start_i,
  input  logic [N_CLASS-1:0]         spikes_i,
  output logic                       busy_o,
  output logic                       net_clr_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [$clog2(N_CLASS)-1:0] class_o,
  output logic [CNT_W-1:0]           count_o,
  output logic                       none_o
);

  localparam int CLS_W = $clog2(N_CLASS);
  localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DECIDE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0] r_cnt [N_CLASS];
  logic [WIN_W-1:0] r_win_cnt;
  logic [CLS_W-1:0] r_scan;
  logic [CLS_W-1:0] r_best_idx;
  logic [CNT_W-1:0] r_best_cnt;
  logic [CLS_W-1:0] r_class;
  logic [CNT_W-1:0] r_count;
  logic             r_none;

`ifdef SPIKE_DEC_FIRST_SPIKE_EN
  logic [WIN_W-1:0] r_ts   [N_CLASS];
  logic [N_CLASS-1:0] r_seen;
  logic [WIN_W-1:0] r_best_ts;
  logic [WIN_W-1:0] w_cand_ts;
  logic [WIN_W-1:0] w_fin_ts;
`endif

  logic             w_launch;
  logic             w_win_last;
  logic             w_scan_last;
  logic [CNT_W-1:0] w_cand_cnt;
  logic             w_take;
  logic [CLS_W-1:0] w_fin_idx;
  logic [CNT_W-1:0] w_fin_cnt;

  assign w_win_last  = (r_win_cnt == WIN_W'(WINDOW - 1));
  assign w_scan_last = (r_scan == CLS_W'(N_CLASS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state; a launch happens from IDLE, or from HOLD on the accepting edge
  always_comb begin
    w_next   = r_state;
    w_launch = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next   = S_RUN;
          w_launch = 1'b1;
        end
      end
      S_RUN:    if (w_win_last)  w_next = S_DECIDE;
      S_DECIDE: if (w_scan_last) w_next = S_HOLD;
      S_HOLD: begin
        if (ready_i) begin
          if (start_i) begin
            w_next   = S_RUN;
            w_launch = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // One scan step: index 0 always seeds the running best; later indices
  // replace it only on a strictly larger count (or, with timestamps, an
  // equal count whose first spike came earlier).
  always_comb begin
    w_cand_cnt = r_cnt[r_scan];
`ifdef SPIKE_DEC_FIRST_SPIKE_EN
    w_cand_ts = r_ts[r_scan];
    w_take = (r_scan == '0) || (w_cand_cnt > r_best_cnt) ||
             ((w_cand_cnt == r_best_cnt) && (w_cand_ts < r_best_ts));
    w_fin_ts = w_take ? w_cand_ts : r_best_ts;
`else
    w_take = (r_scan == '0) || (w_cand_cnt > r_best_cnt);
`endif
    w_fin_idx = w_take ? r_scan     : r_best_idx;
    w_fin_cnt = w_take ? w_cand_cnt : r_best_cnt;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < N_CLASS; k++) r_cnt[k] <= '0;
`ifdef SPIKE_DEC_FIRST_SPIKE_EN
      for (int unsigned k = 0; k < N_CLASS; k++) r_ts[k] <= '0;
      r_seen    <= '0;
      r_best_ts <= '0;
`endif
      r_win_cnt  <= '0;
      r_scan     <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
      r_class    <= '0;
      r_count    <= '0;
      r_none     <= 1'b0;
    end else begin
      if (w_launch) begin
        for (int unsigned k = 0; k < N_CLASS; k++) r_cnt[k] <= '0;
`ifdef SPIKE_DEC_FIRST_SPIKE_EN
        for (int unsigned k = 0; k < N_CLASS; k++) r_ts[k] <= '0;
        r_seen <= '0;
`endif
        r_win_cnt <= '0;
      end else if (r_state == S_RUN) begin
        for (int unsigned k = 0; k < N_CLASS; k++) begin
          if (spikes_i[k] && (r_cnt[k] != '1)) r_cnt[k] <= r_cnt[k] + CNT_W'(1);
`ifdef SPIKE_DEC_FIRST_SPIKE_EN
          if (spikes_i[k] && !r_seen[k]) begin
            r_ts[k]   <= r_win_cnt;
            r_seen[k] <= 1'b1;
          end
`endif
        end
        r_win_cnt <= w_win_last ? '0 : r_win_cnt + WIN_W'(1);
        r_scan    <= '0;
      end

      if (r_state == S_DECIDE) begin
        r_best_idx <= w_fin_idx;
        r_best_cnt <= w_fin_cnt;
`ifdef SPIKE_DEC_FIRST_SPIKE_EN
        r_best_ts  <= w_fin_ts;
`endif
        r_scan     <= r_scan + CLS_W'(1);
        if (w_scan_last) begin
          r_none  <= (w_fin_cnt == '0);
          r_class <= (w_fin_cnt == '0) ? '0 : w_fin_idx;
          r_count <= w_fin_cnt;
        end
      end

      // Result is consumed on the handshake edge
      if ((r_state == S_HOLD) && ready_i) begin
        r_class <= '0;
        r_count <= '0;
        r_none  <= 1'b0;
      end
    end
  end

  // All outputs decode registered state only
  assign busy_o    = (r_state != S_IDLE);
  assign valid_o   = (r_state == S_HOLD);
  assign net_clr_o = (r_state == S_RUN) && (r_win_cnt == '0);
  assign class_o   = r_class;
  assign count_o   = r_count;
  assign none_o    = r_none;

endmodule

// File: tb/tb_spike_decoder.sv
module tb_spike_decoder;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start_i;
  logic [1:0] spikes_i;
  logic       ready_i;

  logic       busy4, clr4, valid4, cls4, none4;
  logic [3:0] cnt4;
  logic       busy3, clr3, valid3, cls3, none3;
  logic [2:0] cnt3;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int cls;
    int cnt;
    bit none;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];

  always #5 clk = ~clk;

  spike_decoder #(.N_CLASS(2), .WINDOW(8), .CNT_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .start_i(start_i), .spikes_i(spikes_i),
    .busy_o(busy4), .net_clr_o(clr4), .valid_o(valid4), .ready_i(ready_i),
    .class_o(cls4), .count_o(cnt4), .none_o(none4)
  );

  spike_decoder #(.N_CLASS(2), .WINDOW(8), .CNT_W(3)) dut3 (
    .clk(clk), .rstn(rstn), .start_i(start_i), .spikes_i(spikes_i),
    .busy_o(busy3), .net_clr_o(clr3), .valid_o(valid3), .ready_i(ready_i),
    .class_o(cls3), .count_o(cnt3), .none_o(none3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: saturating counts, strict-greater scan from index 0
  function automatic exp_t model(input logic [15:0] p, input int maxc);
    exp_t e;
    int c[2];
    int ts[2];
    int best;
    c[0] = 0; c[1] = 0; ts[0] = 99; ts[1] = 99;
    for (int t = 0; t < 8; t++)
      for (int k = 0; k < 2; k++)
        if (p[2*t+k]) begin
          if (c[k] < maxc) c[k]++;
          if (ts[k] == 99) ts[k] = t;
        end
    best = 0;
`ifdef SPIKE_DEC_FIRST_SPIKE_EN
    if (c[1] > c[0] || (c[1] == c[0] && ts[1] < ts[0])) best = 1;
`else
    if (c[1] > c[0]) best = 1;
`endif
    e.none = (c[0] == 0 && c[1] == 0);
    e.cls  = e.none ? 0 : best;
    e.cnt  = c[best];
    return e;
  endfunction

  // Launch a window (from IDLE, or back-to-back from HOLD when b2b=1) and
  // drive 8 RUN cycles of spikes; ends in cycle 9 after the launch edge.
  task automatic run_window(input logic [15:0] pats, input bit b2b);
    q4.push_back(model(pats, 15));
    q3.push_back(model(pats, 7));
    start_i = 1'b1;
    if (b2b) ready_i = 1'b1;
    spikes_i = 2'b00;
    step();
    start_i = 1'b0;
    ready_i = 1'b0;
    checks++;
    if ({clr4, busy4, valid4, clr3, busy3, valid3} !== 6'b110110) begin
      errors++;
      $display("FAIL launch_cycle1 clr/busy/valid x2 got=%b want=110110",
               {clr4, busy4, valid4, clr3, busy3, valid3});
    end
    for (int i = 0; i < 8; i++) begin
      spikes_i = pats[2*i +: 2];
      step();
      checks++;
      if ({clr4, busy4, clr3, busy3} !== 4'b0101) begin
        errors++;
        $display("FAIL run_cycle%0d clr/busy x2 got=%b want=0101", i + 2,
                 {clr4, busy4, clr3, busy3});
      end
    end
    spikes_i = 2'b00;
  endtask

  // Wait for valid (bounded), compare against the scoreboard, then hold
  // ready low for 'stall' cycles checking the result stays put.
  task automatic collect(input int stall);
    exp_t e4, e3;
    int cyc = 9;
    while (valid4 !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
    end
    checks++;
    if (cyc != 11) begin
      errors++;
      $display("FAIL valid_latency cycle got=%0d want=11", cyc);
    end
    checks++;
    if (q4.size() == 0 || q3.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty size got=%0d want>0", q4.size());
      return;
    end
    e4 = q4.pop_front();
    e3 = q3.pop_front();
    for (int s = 0; s <= stall; s++) begin
      checks++;
      if ({valid4, cls4, cnt4, none4} !== {1'b1, 1'(e4.cls), 4'(e4.cnt), e4.none}) begin
        errors++;
        $display("FAIL result_w4 hold%0d valid/cls/cnt/none got=%b/%0d/%0d/%b want=1/%0d/%0d/%b",
                 s, valid4, cls4, cnt4, none4, e4.cls, e4.cnt, e4.none);
      end
      checks++;
      if ({valid3, cls3, cnt3, none3} !== {1'b1, 1'(e3.cls), 3'(e3.cnt), e3.none}) begin
        errors++;
        $display("FAIL result_w3 hold%0d valid/cls/cnt/none got=%b/%0d/%0d/%b want=1/%0d/%0d/%b",
                 s, valid3, cls3, cnt3, none3, e3.cls, e3.cnt, e3.none);
      end
      if (s < stall) step();
    end
  endtask

  task automatic accept();
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    checks++;
    if ({valid4, busy4, valid3, busy3} !== 4'b0000) begin
      errors++;
      $display("FAIL accept valid/busy x2 got=%b want=0000", {valid4, busy4, valid3, busy3});
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; start_i = 1'b0; ready_i = 1'b0; spikes_i = 2'b00;
    step();
    step();
    checks++;
    if ({busy4, clr4, valid4, cls4, cnt4, none4} !== 9'b0) begin
      errors++;
      $display("FAIL reset_w4 outputs got=%b want=0", {busy4, clr4, valid4, cls4, cnt4, none4});
    end
    checks++;
    if ({busy3, clr3, valid3, cls3, cnt3, none3} !== 8'b0) begin
      errors++;
      $display("FAIL reset_w3 outputs got=%b want=0", {busy3, clr3, valid3, cls3, cnt3, none3});
    end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_basic();
    run_window(16'h5555, 1'b0);   // class 0 every cycle
    collect(0);
    accept();
  endtask

  task automatic test_class1_wins();
    run_window(16'h03FA, 1'b0);   // class1 x5, class0 x3
    collect(0);
    accept();
  endtask

  task automatic test_tie();
    // 4/4 tie; class1 first spikes in RUN cycle 1, class0 in RUN cycle 3
    run_window(16'h0F5A, 1'b0);
    collect(0);
    checks++;
`ifdef SPIKE_DEC_FIRST_SPIKE_EN
    if (cls4 !== 1'b1) begin
      errors++;
      $display("FAIL tie_first_spike class got=%b want=1", cls4);
    end
`else
    if (cls4 !== 1'b0) begin
      errors++;
      $display("FAIL tie_lowest_index class got=%b want=0", cls4);
    end
`endif
    accept();
  endtask

  task automatic test_saturate_and_none();
    run_window(16'hFFFF, 1'b0);   // both classes every cycle
    collect(0);
    accept();
    run_window(16'h0000, 1'b0);   // silent window
    collect(0);
    accept();
  endtask

  task automatic test_back_to_back();
    run_window(16'h0A0A, 1'b0);
    collect(5);
    run_window(16'h0055, 1'b1);   // ready and start on the same edge
    collect(0);
    accept();
  endtask

  task automatic test_mid_reset();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    spikes_i = 2'b11;
    for (int i = 0; i < 3; i++) step();
    rstn = 1'b0;                  // asserted during RUN cycle 4
    step();
    checks++;
    if ({busy4, clr4, valid4, cls4, cnt4, none4, busy3, clr3, valid3, cls3, cnt3, none3} !== 17'b0) begin
      errors++;
      $display("FAIL mid_reset outputs got=%b want=0",
               {busy4, clr4, valid4, cls4, cnt4, none4, busy3, clr3, valid3, cls3, cnt3, none3});
    end
    rstn = 1'b1;
    spikes_i = 2'b00;
    step();
    run_window(16'h000A, 1'b0);   // class1 x2 only
    collect(0);
    accept();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_class1_wins();
    test_tie();
    test_saturate_and_none();
    test_back_to_back();
    test_mid_reset();
    checks++;
    if (q4.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover size got=%0d want=0", q4.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
